dbg_mem_dump: RTL and testbench
===============================

DBG_MEM_DUMP -- requirements
Module: dbg_mem_dump

Interface
REQ-001 Parameter START_ADDR, default 16'h0000: first data-memory word address that is dumped.
REQ-002 Parameter WORD_COUNT, default 16: number of words per dump; legal range 1..65536.
REQ-003 Parameter CLKS_PER_BIT, default 868: clk cycles per UART bit; minimum 4.
REQ-004 Parameter RD_LAT, default 2: clk cycles from a dbg_addr change until dbg_data is valid; legal range 1..7.
REQ-005 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 Port rst  input  1: synchronous, active-high reset.
REQ-007 Port start  input  1: single-cycle request to begin a dump.
REQ-008 Port dbg_addr  output  16: word address, connected to the processor's in_debug.
REQ-009 Port dbg_data  input  32: read data, connected to the processor's out_debug.
REQ-010 Port uart_tx  output  1: serial line, 8N1 format, idle high.
REQ-011 Port busy  output  1: high from the cycle after an accepted start until done.
REQ-012 Port done  output  1: one-cycle pulse after the last stop bit of a dump.

Function
REQ-013 The FSM SHALL have the states IDLE, SETADDR, WAIT, CAPTURE, SEND, NEXT and FIN.
REQ-014 IDLE SHALL move to SETADDR when start=1; dbg_addr=START_ADDR and busy=1 SHALL take effect on the next cycle.
REQ-015 A start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-016 WAIT SHALL last exactly RD_LAT cycles after dbg_addr is updated; CAPTURE SHALL then latch dbg_data into a 32-bit shadow register.
REQ-017 SEND SHALL transmit the shadow bytes MSB-first, bits [31:24] then [23:16], [15:8] and [7:0].
REQ-018 Each byte SHALL be sent as a start bit (0), 8 data bits LSB-first, and a stop bit (1), each bit lasting exactly CLKS_PER_BIT cycles.
REQ-019 Consecutive bytes SHALL be back-to-back, with no idle cycles beyond the stop bit.
REQ-020 dbg_addr SHALL remain stable from SETADDR until CAPTURE completes.
REQ-021 NEXT SHALL increment dbg_addr modulo 2^16 (16'hFFFF wraps to 16'h0000) and decrement the 17-bit remaining-word counter.
REQ-022 If the counter reaches 0, the FSM SHALL go to FIN; otherwise it SHALL go to WAIT.
REQ-023 FIN SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-024 A start asserted in the FIN cycle SHALL be ignored.
REQ-025 The total dump length SHALL be WORD_COUNT*(RD_LAT+2+40*CLKS_PER_BIT)+2 cycles, measured from the accepted start to done.
REQ-026 uart_tx SHALL be 1 in every state except SEND.

Reset
REQ-027 With rst=1 at a clock edge, the next cycle SHALL show state=IDLE, uart_tx=1, busy=0, done=0, dbg_addr=16'h0000, shadow register 0, and all counters 0.
REQ-028 Reset asserted mid-dump, including mid-bit, SHALL abort the dump immediately, with no completion of the partial byte and no done pulse.
REQ-029 A start asserted in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-030 With DBG_DUMP_HDR_EN defined, each word SHALL be preceded by a 2-byte header carrying dbg_addr[15:8] then dbg_addr[7:0], giving 6 bytes per word and 60*CLKS_PER_BIT bit-cycles per word in REQ-025.
REQ-031 Without DBG_DUMP_HDR_EN, only the 4 data bytes SHALL be sent, and no header logic SHALL exist.

Structure
REQ-032 The shared package dbg_pkg SHALL hold the FSM state enum, the UART frame constants (start=0, stop=1, 8 data bits), and the header byte count.
REQ-033 A sub-module uart_tx_byte SHALL serialize one byte using the ports clk, rst, load, byte_in, tx, and ready, with ready high for exactly one cycle at the end of the stop bit.
REQ-034 dbg_mem_dump SHALL contain only the FSM, the address register, the word counter, the shadow register, and the byte sequencing.

Verification (CLKS_PER_BIT=4, RD_LAT=2, behavioural 2-cycle-latency memory model)
REQ-035 Load mem[0]=32'hA1B2C3D4, WORD_COUNT=1, pulse start -> uart_tx decodes to bytes A1,B2,C3,D4; done pulses exactly 2+2+2+160 cycles after start.
REQ-036 START_ADDR=16'hFFFE, WORD_COUNT=3 -> dbg_addr sequence is FFFE, FFFF, 0000, with three correct words decoded.
REQ-037 Pulse start again 50 cycles into a dump -> no effect; byte stream and done timing are identical to the single-start run.
REQ-038 Assert rst during bit 3 of byte 2 -> next cycle shows uart_tx=1, busy=0; done never pulses; a new start then yields a full, correct dump.
REQ-039 With DBG_DUMP_HDR_EN, START_ADDR=16'h0010, mem[16]=32'h12345678 -> bytes are 00,10,12,34,56,78.
REQ-040 Line checks on every frame: each start bit lasts 4 cycles low and each stop bit 4 cycles high; uart_tx=1 whenever busy=0.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared definitions for the debug memory dumper: FSM states, UART frame
// constants and byte-layout helpers.
package dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETADDR,
    ST_WAIT,
    ST_CAPTURE,
    ST_SEND,
    ST_NEXT,
    ST_FIN
  } dump_state_t;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = UART_DATA_BITS + 2;

  localparam int HDR_BYTES  = 2;
  localparam int DATA_BYTES = 4;

  // Byte idx of a word, most significant byte first.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [2:0] idx);
    case (idx)
      3'd0:    return w[31:24];
      3'd1:    return w[23:16];
      3'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A load on the final stop-bit cycle (ready=1) chains
// the next frame with no idle gap.
module uart_tx_byte
  import dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       ready
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [UART_FRAME_BITS-1:0] frame;
  logic                       active;
  logic [3:0]                 bit_idx;
  logic [CW-1:0]              clk_cnt;
  logic                       last_clk;
  logic                       last_bit;

  assign last_clk = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_idx == 4'(UART_FRAME_BITS - 1));
  assign ready    = active && last_clk && last_bit;
  assign tx       = active ? frame[0] : UART_STOP_BIT;

  // load is only honoured when idle or on the closing stop-bit cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      frame   <= '0;
      active  <= 1'b0;
      bit_idx <= '0;
      clk_cnt <= '0;
    end else if (load && (!active || ready)) begin
      frame   <= {UART_STOP_BIT, byte_in, UART_START_BIT};
      active  <= 1'b1;
      bit_idx <= '0;
      clk_cnt <= '0;
    end else if (active) begin
      if (last_clk) begin
        clk_cnt <= '0;
        if (last_bit) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          frame   <= {UART_STOP_BIT, frame[UART_FRAME_BITS-1:1]};
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dbg_mem_dump.sv
// Dumps WORD_COUNT data-memory words over an 8N1 UART, MSB byte first.
// Define DBG_DUMP_HDR_EN to prefix each word with its 16-bit address.
module dbg_mem_dump
  import dbg_pkg::*;
#(
  parameter logic [15:0] START_ADDR   = 16'h0000,
  parameter int          WORD_COUNT   = 16,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          RD_LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

`ifdef DBG_DUMP_HDR_EN
  localparam int NBYTES = HDR_BYTES + DATA_BYTES;
`else
  localparam int NBYTES = DATA_BYTES;
`endif

  dump_state_t state, state_nxt;
  logic [2:0]  wait_cnt;
  logic [16:0] remaining;
  logic [31:0] shadow;
  logic [2:0]  byte_idx;
  logic [2:0]  byte_sel;
  logic [31:0] cur_word;
  logic        tx_load;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_line;
  logic        last_byte;

  assign last_byte = (byte_idx == 3'(NBYTES));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_SETADDR;
      ST_SETADDR: state_nxt = ST_WAIT;
      ST_WAIT:    if (wait_cnt == 3'(RD_LAT - 1)) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_SEND;
      ST_SEND:    if (tx_ready && last_byte) state_nxt = ST_NEXT;
      ST_NEXT:    state_nxt = (remaining == 17'd1) ? ST_FIN : ST_WAIT;
      ST_FIN:     state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_addr  <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      shadow    <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          dbg_addr  <= START_ADDR;
          remaining <= 17'(WORD_COUNT);
        end
        ST_SETADDR: wait_cnt <= '0;
        ST_WAIT:    wait_cnt <= wait_cnt + 3'd1;
        ST_CAPTURE: begin
          shadow   <= dbg_data;
          byte_idx <= 3'd1;
        end
        ST_SEND: if (tx_ready && !last_byte) byte_idx <= byte_idx + 3'd1;
        ST_NEXT: begin
          dbg_addr  <= dbg_addr + 16'd1;
          remaining <= remaining - 17'd1;
          wait_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  // The first byte is loaded in CAPTURE straight from the bus, in the same
  // cycle the shadow latches it, so the frames start on the first SEND cycle.
  always_comb begin
    busy     = (state != ST_IDLE) && (state != ST_FIN);
    done     = (state == ST_FIN);
    byte_sel = (state == ST_CAPTURE) ? 3'd0 : byte_idx;
    cur_word = (state == ST_CAPTURE) ? dbg_data : shadow;
    tx_load  = (state == ST_CAPTURE) || ((state == ST_SEND) && tx_ready && !last_byte);
`ifdef DBG_DUMP_HDR_EN
    if (byte_sel == 3'd0)      tx_byte = dbg_addr[15:8];
    else if (byte_sel == 3'd1) tx_byte = dbg_addr[7:0];
    else                       tx_byte = word_byte(cur_word, byte_sel - 3'(HDR_BYTES));
`else
    tx_byte = word_byte(cur_word, byte_sel);
`endif
    uart_tx = tx_line;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .load   (tx_load),
    .byte_in(tx_byte),
    .tx     (tx_line),
    .ready  (tx_ready)
  );

endmodule

// File: tb/tb_dbg_mem_dump.sv
// Scoreboard bench for dbg_mem_dump: two instances (single word at 0, three
// words wrapping past FFFF) decoded by a UART line monitor.
module tb_dbg_mem_dump;

  localparam int CPB = 4;
  localparam int RDL = 2;
`ifdef DBG_DUMP_HDR_EN
  localparam int BPW = 6;
`else
  localparam int BPW = 4;
`endif
  localparam logic [15:0] SA_A = 16'h0000;
  localparam logic [15:0] SA_B = 16'hFFFE;
  localparam int WC_A = 1;
  localparam int WC_B = 3;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] addr_a, addr_b;
  logic [31:0] data_a, data_b, rd1_a, rd1_b;
  logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] mem [0:65535];

  int n_chk = 0;
  int n_err = 0;
  int sel   = 0;
  logic [7:0]  exp_q [$];
  logic [15:0] addr_q[$];

  initial forever #5 clk = ~clk;

  dbg_mem_dump #(.START_ADDR(SA_A), .WORD_COUNT(WC_A), .CLKS_PER_BIT(CPB), .RD_LAT(RDL)) dut_a (
    .clk(clk), .rst(rst), .start(start && sel == 0), .dbg_addr(addr_a), .dbg_data(data_a),
    .uart_tx(tx_a), .busy(busy_a), .done(done_a));

  dbg_mem_dump #(.START_ADDR(SA_B), .WORD_COUNT(WC_B), .CLKS_PER_BIT(CPB), .RD_LAT(RDL)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel == 1), .dbg_addr(addr_b), .dbg_data(data_b),
    .uart_tx(tx_b), .busy(busy_b), .done(done_b));

  // 2-cycle read latency memory per instance
  always @(posedge clk) begin
    rd1_a  <= mem[addr_a];
    data_a <= rd1_a;
    rd1_b  <= mem[addr_b];
    data_b <= rd1_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_lat(input int wc);
    return wc * (RDL + 2 + BPW * 10 * CPB) + 2;
  endfunction

  task automatic push_dump(input logic [15:0] sa, input int wc);
    logic [15:0] a;
    logic [31:0] d;
    for (int w = 0; w < wc; w++) begin
      a = sa + 16'(w);
      d = mem[a];
`ifdef DBG_DUMP_HDR_EN
      exp_q.push_back(a[15:8]);
      exp_q.push_back(a[7:0]);
`endif
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end
  endtask

  // UART line monitor: decodes frames on the selected instance
  bit         in_frame = 0;
  int         fcyc = 0;
  logic [7:0] rx;
  logic       prev_busy_b = 0;
  logic [15:0] prev_addr_b = '0;

  always @(negedge clk) begin
    logic ln;
    int bi, ph;
    ln = (sel == 1) ? tx_b : tx_a;
    if (rst) begin
      in_frame = 0;
      exp_q.delete();
    end else begin
      if (!busy_a) chk("idle_high_a", tx_a, 1);
      if (!busy_b) chk("idle_high_b", tx_b, 1);
      if (!in_frame && ln == 1'b0) begin
        in_frame = 1;
        fcyc     = 0;
      end
      if (in_frame) begin
        bi = fcyc / CPB;
        ph = fcyc % CPB;
        if (bi == 0)      chk("start_bit", ln, 0);
        else if (bi == 9) chk("stop_bit", ln, 1);
        else if (ph == 0) rx[bi-1] = ln;
        else              chk("data_stable", ln, rx[bi-1]);
        if (fcyc == 10 * CPB - 1) begin
          in_frame = 0;
          if (exp_q.size() == 0) chk("extra_byte", 32'(rx), 32'hFFFF_FFFF);
          else                   chk("byte", 32'(rx), 32'(exp_q.pop_front()));
        end else begin
          fcyc++;
        end
      end
    end
    if (sel == 1 && busy_b && (!prev_busy_b || addr_b != prev_addr_b)) addr_q.push_back(addr_b);
    prev_busy_b = busy_b;
    prev_addr_b = addr_b;
  end

  // One dump on instance s; extra = cycle of a second start, abort_at = cycle of rst
  task automatic run_dump(input int s, input int extra, input int abort_at);
    logic [15:0] sa;
    int wc, lat, len, done_n;
    logic dn, bsy, ln;
    logic [15:0] ad;
    sa     = (s == 1) ? SA_B : SA_A;
    wc     = (s == 1) ? WC_B : WC_A;
    lat    = exp_lat(wc);
    len    = (abort_at >= 0) ? 400 : lat + 3;
    done_n = -1;
    sel    = s;
    addr_q.delete();
    push_dump(sa, wc);
    @(posedge clk); #1;
    start = 1;
    for (int n = 0; n < len; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        start = (n == extra);
        rst   = (n == abort_at);
      end
      @(negedge clk);
      dn  = (s == 1) ? done_b : done_a;
      bsy = (s == 1) ? busy_b : busy_a;
      ln  = (s == 1) ? tx_b : tx_a;
      ad  = (s == 1) ? addr_b : addr_a;
      if (n == 0) chk("busy_before_start", bsy, 0);
      if (n == 1) begin
        chk("busy_after_start", bsy, 1);
        chk("addr_first", ad, sa);
      end
      if (abort_at >= 0 && n == abort_at + 1) begin
        chk("abort_tx", ln, 1);
        chk("abort_busy", bsy, 0);
      end
      if (dn && done_n < 0) done_n = n;
      else if (done_n >= 0 && n == done_n + 1) begin
        chk("done_width", dn, 0);
        chk("busy_after_done", bsy, 0);
      end
      if (done_n >= 0 && n == done_n + 2) chk("busy_fin_start", bsy, 0);
    end
    start = 0;
    rst   = 0;
    if (abort_at >= 0) chk("abort_no_done", done_n, -1);
    else               chk("done_latency", done_n, lat);
    chk("bytes_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h0000] = 32'hA1B2C3D4;
    mem[16'hFFFE] = 32'h11223344;
    mem[16'hFFFF] = 32'h55667788;
    rst   = 1;
    start = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_addr_a", addr_a, 16'h0000);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_addr_b", addr_b, 16'h0000);
    @(posedge clk); #1;
    rst   = 0;
    start = 0;
    @(negedge clk);
    chk("start_in_rst_ignored", busy_a, 0);

    run_dump(0, -1, -1);
    run_dump(0, 50, -1);
    run_dump(1, exp_lat(WC_B), -1);
    chk("addr_seq_len", addr_q.size(), 3);
    if (addr_q.size() == 3) begin
      chk("addr_seq0", addr_q[0], 16'hFFFE);
      chk("addr_seq1", addr_q[1], 16'hFFFF);
      chk("addr_seq2", addr_q[2], 16'h0000);
    end
    run_dump(0, -1, 58);
    run_dump(0, -1, -1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
